pll_freq_tracker: RTL and testbench

- Sits directly downstream of the PLL phase detector and upstream of the SWIPT output driver.
- Counts phase-detector up/down indications over a fixed window of clock cycles and turns the net count into a bounded frequency correction.
- Produces a registered drive-frequency word for the output driver, plus lock and saturation status.
- Tracking runs only while the SWIPT heartbeat reports the link alive.

---
 rtl/pll_freq_tracker.sv | 204 ++++++++++++++++++++
 tb/tb_pll_freq_tracker.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_freq_tracker.sv
// Frequency tracker. Sums phase-detector up/down samples over a fixed window and steps the drive frequency.
// Latency: freq_out, freq_valid and lock status update one cycle after the last sample of each window.
// Backpressure: none. pd inputs are sampled every TRACK cycle, and freq_valid is a bare pulse with no ready.
module pll_freq_tracker #(
    parameter int unsigned F_INIT       = 40000,
    parameter int unsigned F_MIN        = 30000,
    parameter int unsigned F_MAX        = 50000,
    parameter int unsigned WINDOW       = 1000,
    parameter int unsigned GAIN_SHIFT   = 3,
    parameter int unsigned MAX_STEP     = 500,
    parameter int unsigned DEADBAND     = 2,
    parameter int unsigned UNLOCK_BAND  = 8,
    parameter int unsigned LOCK_WINDOWS = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    input  logic        pd_up,
    input  logic        pd_dn,
    output logic [31:0] freq_out,
    output logic        freq_valid,
    output logic        locked,
    output logic        freq_sat
);

    localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int LCW = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WCW-1:0]     WIN_LAST    = WCW'(WINDOW - 1);
    localparam logic [LCW-1:0]     LOCK_FULL   = LCW'(LOCK_WINDOWS);
    localparam logic signed [15:0] NET_POS_LIM = 16'sd32767;
    localparam logic signed [15:0] NET_NEG_LIM = -16'sd32767;
    localparam logic [15:0]        DEAD_MAG    = 16'(DEADBAND);
    localparam logic [15:0]        UNLOCK_MAG  = 16'(UNLOCK_BAND);
    localparam logic [31:0]        STEP_CAP    = 32'(MAX_STEP);
    localparam logic signed [32:0] LIM_LO      = 33'(F_MIN);
    localparam logic signed [32:0] LIM_HI      = 33'(F_MAX);
    localparam logic [31:0]        F_START     = 32'(F_INIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic signed [15:0] net_q, net_d;
    logic [LCW-1:0]     lcnt_q, lcnt_d;
    logic [31:0]        freq_q, freq_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               sat_q, sat_d;

    // Datapath: the net count including this cycle's sample, plus the candidate frequency if this cycle closes the window
    logic signed [15:0] net_acc;
    logic [15:0]        mag;
    logic [31:0]        shifted;
    logic [31:0]        capped;
    logic [31:0]        step;
    logic signed [32:0] raw_freq;
    logic signed [32:0] clamp_freq;
    logic               in_band;
    logic               mid_band;
    logic               clamp_hit;

    // Window arithmetic: saturating accumulate, step size, and clamp to the legal drive range
    always_comb begin
        net_acc = net_q;
        if (pd_up && !pd_dn && (net_q != NET_POS_LIM)) begin
            net_acc = net_q + 16'sd1;
        end else if (pd_dn && !pd_up && (net_q != NET_NEG_LIM)) begin
            net_acc = net_q - 16'sd1;
        end

        mag      = net_acc[15] ? $unsigned(-net_acc) : $unsigned(net_acc);
        shifted  = {16'd0, mag} >> GAIN_SHIFT;
        in_band  = (mag <= DEAD_MAG);
        mid_band = !in_band && (mag <= UNLOCK_MAG);

        capped = (shifted > STEP_CAP) ? STEP_CAP : shifted;
        if (in_band) begin
            step = 32'd0;
        end else if (capped == 32'd0) begin
            step = 32'd1;
        end else begin
            step = capped;
        end

        // A drive that lags pushes the frequency up, and a drive that leads pulls it down.
        if (net_acc[15]) begin
            raw_freq = $signed({1'b0, freq_q}) - $signed({1'b0, step});
        end else begin
            raw_freq = $signed({1'b0, freq_q}) + $signed({1'b0, step});
        end

        if (raw_freq < LIM_LO) begin
            clamp_freq = LIM_LO;
        end else if (raw_freq > LIM_HI) begin
            clamp_freq = LIM_HI;
        end else begin
            clamp_freq = raw_freq;
        end

        // Saturated means the result was clipped, or a nonzero step landed the result on a rail.
        clamp_hit = (clamp_freq != raw_freq) ||
                    ((step != 32'd0) && ((clamp_freq == LIM_LO) || (clamp_freq == LIM_HI)));
    end

    // Control: heartbeat loss wins over everything, then IDLE -> LOAD -> TRACK with a window update at each window end
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        net_d    = net_q;
        lcnt_d   = lcnt_q;
        freq_d   = freq_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        sat_d    = sat_q;

        if (!swiptAlive) begin
            // Frequency and saturation flag stay as they are, so the driver keeps its last good setting.
            state_d  = ST_IDLE;
            wcnt_d   = '0;
            net_d    = '0;
            lcnt_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                    net_d   = '0;
                    lcnt_d  = '0;
                end
                ST_LOAD: begin
                    state_d  = ST_TRACK;
                    freq_d   = F_START;
                    sat_d    = 1'b0;
                    locked_d = 1'b0;
                    lcnt_d   = '0;
                    wcnt_d   = '0;
                    net_d    = '0;
                end
                ST_TRACK: begin
                    if (wcnt_q == WIN_LAST) begin
                        // This cycle's sample is the last one in the window. The next cycle's sample starts the new window.
                        wcnt_d  = '0;
                        net_d   = '0;
                        valid_d = 1'b1;
                        freq_d  = clamp_freq[31:0];
                        sat_d   = clamp_hit;
                        if (in_band) begin
                            lcnt_d = (lcnt_q == LOCK_FULL) ? LOCK_FULL : lcnt_q + 1'b1;
                            if ((lcnt_q == LOCK_FULL) || (lcnt_q + 1'b1 == LOCK_FULL)) begin
                                locked_d = 1'b1;
                            end
                        end else if (mid_band) begin
                            lcnt_d = '0;
                        end else begin
                            lcnt_d   = '0;
                            locked_d = 1'b0;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                        net_d  = net_acc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers. Reset takes effect immediately, so a partial window is never applied.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            net_q    <= '0;
            lcnt_q   <= '0;
            freq_q   <= F_START;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            net_q    <= net_d;
            lcnt_q   <= lcnt_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            sat_q    <= sat_d;
        end
    end

    assign freq_out   = freq_q;
    assign freq_valid = valid_q;
    assign locked     = locked_q;
    assign freq_sat   = sat_q;

endmodule

// File: tb/tb_pll_freq_tracker.sv
// Bench for pll_freq_tracker. Two instances share the stimulus and differ only in start frequency (mid-range and near the upper rail).
// Latency: expects results one cycle after each window's last sample.
// Backpressure: none. Stimulus is driven every cycle.
module tb_pll_freq_tracker;

    localparam int WIN     = 16;
    localparam int GS      = 2;
    localparam int DB      = 1;
    localparam int UB      = 4;
    localparam int LW      = 3;
    localparam int FMIN    = 30000;
    localparam int FMAX    = 50000;
    localparam int MSTEP   = 500;
    localparam int FINIT_A = 40000;
    localparam int FINIT_B = 49998;

    logic        clk = 1'b0;
    logic        nrst;
    logic        alive;
    logic        pd_up;
    logic        pd_dn;
    logic [31:0] freq_a, freq_b;
    logic        val_a, val_b, lock_a, lock_b, sat_a, sat_b;

    int n_chk  = 0;
    int n_pass = 0;

    pll_freq_tracker #(
        .F_INIT(FINIT_A), .F_MIN(FMIN), .F_MAX(FMAX), .WINDOW(WIN), .GAIN_SHIFT(GS),
        .MAX_STEP(MSTEP), .DEADBAND(DB), .UNLOCK_BAND(UB), .LOCK_WINDOWS(LW)
    ) dut_a (
        .clk(clk), .nrst(nrst), .swiptAlive(alive), .pd_up(pd_up), .pd_dn(pd_dn),
        .freq_out(freq_a), .freq_valid(val_a), .locked(lock_a), .freq_sat(sat_a)
    );

    pll_freq_tracker #(
        .F_INIT(FINIT_B), .F_MIN(FMIN), .F_MAX(FMAX), .WINDOW(WIN), .GAIN_SHIFT(GS),
        .MAX_STEP(MSTEP), .DEADBAND(DB), .UNLOCK_BAND(UB), .LOCK_WINDOWS(LW)
    ) dut_b (
        .clk(clk), .nrst(nrst), .swiptAlive(alive), .pd_up(pd_up), .pd_dn(pd_dn),
        .freq_out(freq_b), .freq_valid(val_b), .locked(lock_b), .freq_sat(sat_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model. It counts how long the heartbeat has been up, collects one window's samples, and applies the window rules.
    int  m_run, m_wsum, m_wlen, m_lcnt;
    bit  m_locked, m_valid;
    int  m_freq[2];
    bit  m_sat[2];

    task automatic model_reset();
        m_run = 0; m_wsum = 0; m_wlen = 0; m_lcnt = 0;
        m_locked = 1'b0; m_valid = 1'b0;
        m_freq[0] = FINIT_A; m_freq[1] = FINIT_B;
        m_sat[0] = 1'b0; m_sat[1] = 1'b0;
    endtask

    task automatic model_edge(input bit a, input bit up, input bit dn);
        int mag, step, nxt, clp;
        m_valid = 1'b0;
        if (!a) begin
            m_run = 0; m_wsum = 0; m_wlen = 0; m_lcnt = 0; m_locked = 1'b0;
        end else begin
            if (m_run < 3) m_run++;
            if (m_run == 2) begin
                m_freq[0] = FINIT_A; m_freq[1] = FINIT_B;
                m_sat[0] = 1'b0; m_sat[1] = 1'b0;
                m_locked = 1'b0; m_lcnt = 0; m_wsum = 0; m_wlen = 0;
            end else if (m_run == 3) begin
                if (up && !dn) m_wsum = (m_wsum < 32767) ? m_wsum + 1 : 32767;
                else if (dn && !up) m_wsum = (m_wsum > -32767) ? m_wsum - 1 : -32767;
                m_wlen++;
                if (m_wlen == WIN) begin
                    mag = (m_wsum < 0) ? -m_wsum : m_wsum;
                    if (mag <= DB) step = 0;
                    else begin
                        step = mag >> GS;
                        if (step > MSTEP) step = MSTEP;
                        if (step < 1) step = 1;
                    end
                    for (int i = 0; i < 2; i++) begin
                        nxt = (m_wsum < 0) ? m_freq[i] - step : m_freq[i] + step;
                        clp = (nxt < FMIN) ? FMIN : (nxt > FMAX) ? FMAX : nxt;
                        m_sat[i]  = (clp != nxt) || (step != 0 && (clp == FMIN || clp == FMAX));
                        m_freq[i] = clp;
                    end
                    if (mag <= DB) begin
                        m_lcnt = (m_lcnt < LW) ? m_lcnt + 1 : LW;
                        if (m_lcnt == LW) m_locked = 1'b1;
                    end else if (mag <= UB) begin
                        m_lcnt = 0;
                    end else begin
                        m_lcnt = 0; m_locked = 1'b0;
                    end
                    m_valid = 1'b1;
                    m_wsum  = 0;
                    m_wlen  = 0;
                end
            end
        end
    endtask

    // One window of 16 samples: 'up' cycles of pd_up, then 'dn' cycles of pd_dn, then 'both' cycles of both, then idle.
    task automatic run_window(input int up, input int dn, input int both);
        for (int c = 0; c < WIN; c++) begin
            pd_up = (c < up) || (c >= up + dn && c < up + dn + both);
            pd_dn = (c >= up && c < up + dn) || (c >= up + dn && c < up + dn + both);
            @(posedge clk);
            #1;
            if (c < WIN - 1) chk("valid_mid_window", val_a, 0);
        end
        pd_up = 1'b0;
        pd_dn = 1'b0;
    endtask

    typedef struct {
        int up;
        int dn;
        int both;
        int fa;
        int fb;
        bit sb;
        bit lk;
    } win_t;

    initial begin
        win_t tbl[16];
        bit   lk_exp[3];
        int   mode;
        int   r;
        int   drop_cnt;

        tbl[0]  = '{16, 0,  0, 40004, 50000, 1'b1, 1'b0};
        tbl[1]  = '{ 0, 16, 0, 40000, 49996, 1'b0, 1'b0};
        tbl[2]  = '{ 0, 1,  0, 40000, 49996, 1'b0, 1'b0};
        tbl[3]  = '{ 0, 1,  0, 40000, 49996, 1'b0, 1'b0};
        tbl[4]  = '{ 0, 1,  0, 40000, 49996, 1'b0, 1'b1};
        tbl[5]  = '{ 6, 0,  0, 40001, 49997, 1'b0, 1'b0};
        tbl[6]  = '{ 0, 0, 16, 40001, 49997, 1'b0, 1'b0};
        tbl[7]  = '{ 0, 0,  0, 40001, 49997, 1'b0, 1'b0};
        tbl[8]  = '{ 0, 0, 16, 40001, 49997, 1'b0, 1'b1};
        tbl[9]  = '{ 3, 0,  0, 40002, 49998, 1'b0, 1'b1};
        tbl[10] = '{ 0, 2,  0, 40001, 49997, 1'b0, 1'b1};
        tbl[11] = '{ 5, 0,  0, 40002, 49998, 1'b0, 1'b0};
        tbl[12] = '{16, 0,  0, 40006, 50000, 1'b1, 1'b0};
        tbl[13] = '{16, 0,  0, 40010, 50000, 1'b1, 1'b0};
        tbl[14] = '{ 0, 1,  0, 40010, 50000, 1'b0, 1'b0};
        tbl[15] = '{ 0, 16, 0, 40006, 49996, 1'b0, 1'b0};
        lk_exp[0] = 1'b0; lk_exp[1] = 1'b0; lk_exp[2] = 1'b1;

        nrst = 1'b0; alive = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freq_a", freq_a, FINIT_A);
        chk("rst_freq_b", freq_b, FINIT_B);
        chk("rst_valid", val_a, 0);
        chk("rst_locked", lock_a, 0);
        chk("rst_sat_b", sat_b, 0);

        // Release with heartbeat up: one edge into LOAD, one edge into TRACK, then the window begins.
        alive = 1'b1; nrst = 1'b1;
        @(posedge clk); #1;
        chk("load_freq_a", freq_a, FINIT_A);
        chk("load_valid", val_a, 0);
        @(posedge clk); #1;
        chk("track_freq_a", freq_a, FINIT_A);
        chk("track_valid", val_a, 0);
        chk("track_locked", lock_a, 0);

        for (int i = 0; i < 16; i++) begin
            run_window(tbl[i].up, tbl[i].dn, tbl[i].both);
            chk("tbl_valid_a", val_a, 1);
            chk("tbl_valid_b", val_b, 1);
            chk("tbl_freq_a", freq_a, tbl[i].fa);
            chk("tbl_freq_b", freq_b, tbl[i].fb);
            chk("tbl_sat_a", sat_a, 0);
            chk("tbl_sat_b", sat_b, tbl[i].sb);
            chk("tbl_locked", lock_a, tbl[i].lk);
        end

        // Three quiet windows in a row bring up lock.
        for (int i = 0; i < 3; i++) begin
            run_window(0, 0, 0);
            chk("lock_seq_valid", val_a, 1);
            chk("lock_seq_locked", lock_b, lk_exp[i]);
        end

        // Heartbeat drops at cycle 8 of a locked window.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("pre_drop_valid", val_a, 0);
        end
        alive = 1'b0;
        @(posedge clk); #1;
        chk("drop_locked", lock_a, 0);
        chk("drop_valid", val_a, 0);
        chk("drop_freq_a", freq_a, 40006);
        chk("drop_freq_b", freq_b, 49996);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_no_valid", val_a | val_b, 0);
        end
        chk("idle_freq_held", freq_a, 40006);
        alive = 1'b1;
        @(posedge clk); #1;
        chk("reraise_load_freq_a", freq_a, 40006);
        @(posedge clk); #1;
        chk("reraise_freq_a", freq_a, FINIT_A);
        chk("reraise_freq_b", freq_b, FINIT_B);
        chk("reraise_sat_b", sat_b, 0);
        chk("reraise_locked", lock_a, 0);
        run_window(16, 0, 0);
        chk("post_load_valid", val_a, 1);
        chk("post_load_freq_a", freq_a, 40004);
        chk("post_load_freq_b", freq_b, 50000);
        chk("post_load_sat_b", sat_b, 1);

        // Asynchronous reset in the middle of a window, away from any clock edge.
        pd_up = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_freq_a", freq_a, FINIT_A);
        chk("async_rst_freq_b", freq_b, FINIT_B);
        chk("async_rst_sat_b", sat_b, 0);
        chk("async_rst_valid", val_a, 0);
        chk("async_rst_locked", lock_a, 0);

        // Random phase checked against the reference model on every cycle.
        model_reset();
        mode = 0;
        drop_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nrst = 1'b1;
            if (cyc % 16 == 0) mode = $urandom_range(0, 5);
            r = $urandom_range(0, 99);
            case (mode)
                0: begin pd_up = (r < 5);  pd_dn = (r >= 95); end
                1: begin pd_up = (r < 60); pd_dn = (r >= 90); end
                2: begin pd_dn = (r < 60); pd_up = (r >= 90); end
                3: begin pd_up = 1'($urandom_range(0, 1)); pd_dn = 1'($urandom_range(0, 1)); end
                4: begin pd_up = (r < 70); pd_dn = (r < 70); end
                default: begin pd_up = 1'b0; pd_dn = 1'b0; end
            endcase
            if (drop_cnt > 0) begin
                alive = 1'b0;
                drop_cnt--;
            end else if ($urandom_range(0, 199) == 0) begin
                alive = 1'b0;
                drop_cnt = $urandom_range(0, 2);
            end else begin
                alive = 1'b1;
            end

            @(posedge clk);
            model_edge(alive, pd_up, pd_dn);
            #1;
            chk("rnd_freq_a", freq_a, m_freq[0]);
            chk("rnd_freq_b", freq_b, m_freq[1]);
            chk("rnd_sat_a", sat_a, m_sat[0]);
            chk("rnd_sat_b", sat_b, m_sat[1]);
            chk("rnd_valid_a", val_a, m_valid);
            chk("rnd_valid_b", val_b, m_valid);
            chk("rnd_locked_a", lock_a, m_locked);
            chk("rnd_locked_b", lock_b, m_locked);

            if ($urandom_range(0, 699) == 0) begin
                #2;
                nrst = 1'b0;
                model_reset();
                #1;
                chk("rnd_rst_freq_a", freq_a, m_freq[0]);
                chk("rnd_rst_freq_b", freq_b, m_freq[1]);
                chk("rnd_rst_locked", lock_a, m_locked);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
